// File: rtl/acc_exec_pkg.sv
// acc_exec_pkg: opcode/modifier constants, FSM state type
// and instruction bundle shared by the accumulator unit.
package acc_exec_pkg;

   localparam logic [3:0] OPR_NOP = 4'h0;
   localparam logic [3:0] OPR_ADD = 4'h8;
   localparam logic [3:0] OPR_SUB = 4'h9;
   localparam logic [3:0] OPR_LD  = 4'hA;
   localparam logic [3:0] OPR_XCH = 4'hB;
   localparam logic [3:0] OPR_ACC = 4'hF;

   localparam logic [3:0] OPA_CLB = 4'h0;
   localparam logic [3:0] OPA_CLC = 4'h1;
   localparam logic [3:0] OPA_IAC = 4'h2;
   localparam logic [3:0] OPA_CMC = 4'h3;
   localparam logic [3:0] OPA_CMA = 4'h4;
   localparam logic [3:0] OPA_RAL = 4'h5;
   localparam logic [3:0] OPA_RAR = 4'h6;
   localparam logic [3:0] OPA_TCC = 4'h7;
   localparam logic [3:0] OPA_DAC = 4'h8;
   localparam logic [3:0] OPA_STC = 4'h9;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      EXEC
   } state_t;

   typedef struct packed {
      logic [3:0] opr;
      logic [3:0] opa;
   } instr_t;

   function automatic logic is_reg_op(
      input logic [3:0] opr
   );
      return (opr == OPR_ADD) || (opr == OPR_SUB) ||
             (opr == OPR_LD)  || (opr == OPR_XCH);
   endfunction

   function automatic logic is_legal(
      input logic [3:0] opr,
      input logic [3:0] opa
   );
      return (opr == OPR_NOP) || is_reg_op(opr) ||
             ((opr == OPR_ACC) && (opa <= OPA_STC));
   endfunction

endpackage

// File: rtl/acc_exec_alu.sv
// acc_alu: combinational datapath producing next {carry,acc},
// register write value/enable and illegal flag for one op.
module acc_alu
   import acc_exec_pkg::*;
#(
   parameter int DATA_W = 4
) (
   input  logic [3:0]        opr,
   input  logic [3:0]        opa,
   input  logic [DATA_W-1:0] acc,
   input  logic              carry,
   input  logic [DATA_W-1:0] operand,
   output logic [DATA_W-1:0] acc_nxt,
   output logic              carry_nxt,
   output logic              reg_we,
   output logic [DATA_W-1:0] reg_wdata,
   output logic              illegal
);

   logic [DATA_W:0] sum;
   logic [DATA_W:0] acc_x;
   logic [DATA_W:0] opd_x;
   logic [DATA_W:0] cin_x;
   logic [DATA_W:0] bin_x;

   assign acc_x = {1'b0, acc};
   assign opd_x = {1'b0, operand};
   assign cin_x = {{DATA_W{1'b0}}, carry};
   assign bin_x = {{DATA_W{1'b0}}, ~carry};

   always_comb begin
      sum       = {carry, acc};
      reg_we    = 1'b0;
      reg_wdata = acc;
      illegal   = !is_legal(opr, opa);
      unique case (1'b1)
         (opr == OPR_ADD): sum = acc_x + opd_x + cin_x;
         (opr == OPR_SUB): sum = acc_x + {1'b0, ~operand} + bin_x;
         (opr == OPR_LD):  sum = {carry, operand};
         (opr == OPR_XCH): begin
            sum    = {carry, operand};
            reg_we = 1'b1;
         end
         (opr == OPR_ACC): begin
            unique case (opa)
               OPA_CLB: sum = '0;
               OPA_CLC: sum = {1'b0, acc};
               OPA_IAC: sum = acc_x + {{DATA_W{1'b0}}, 1'b1};
               OPA_CMC: sum = {~carry, acc};
               OPA_CMA: sum = {carry, ~acc};
               OPA_RAL: sum = {acc, carry};
               // rotate right through carry: lsb leaves into carry
               OPA_RAR: sum = {acc[0], carry, acc[DATA_W-1:1]};
               OPA_TCC: sum = cin_x;
               OPA_DAC: sum = acc_x + {1'b0, {DATA_W{1'b1}}};
               OPA_STC: sum = {1'b1, acc};
               default: sum = {carry, acc};
            endcase
         end
         default: sum = {carry, acc};
      endcase
   end

   assign acc_nxt   = sum[DATA_W-1:0];
   assign carry_nxt = sum[DATA_W];

endmodule

// File: rtl/acc_exec_unit.sv
// acc_exec_unit: 3-state accumulator executor with register file,
// host write port, retire counter and valid/ready instruction input.
module acc_exec_unit
   import acc_exec_pkg::*;
#(
   parameter int DATA_W = 4,
   parameter int NREG   = 16,
   parameter int CNT_W  = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    instr_valid,
   input  logic [3:0]              opr,
   input  logic [3:0]              opa,
   output logic                    instr_ready,
   input  logic                    host_we,
   input  logic [$clog2(NREG)-1:0] host_addr,
   input  logic [DATA_W-1:0]       host_wdata,
   input  logic [$clog2(NREG)-1:0] rd_addr,
   output logic [DATA_W-1:0]       rd_data,
   output logic [DATA_W-1:0]       acc,
   output logic                    carry,
   output logic                    done,
   output logic                    illegal,
   output logic [CNT_W-1:0]        instr_count
);

   localparam int AW = $clog2(NREG);

   state_t state;
   state_t state_nxt;
   instr_t ir;

   logic [DATA_W-1:0] regs [NREG];
   logic [DATA_W-1:0] operand;
   logic [AW-1:0]     ridx;
   logic              accept;

   logic [DATA_W-1:0] acc_nxt;
   logic              carry_nxt;
   logic              reg_we;
   logic [DATA_W-1:0] reg_wdata;
   logic              alu_ill;
   logic              exec;
   logic              host_ok;

   assign instr_ready = (state == IDLE);
   assign accept      = instr_valid && instr_ready;
   assign ridx        = ir.opa[AW-1:0];
   assign exec        = (state == EXEC);
   assign host_ok     = host_we && (state == IDLE);
   assign rd_data     = regs[rd_addr];

   acc_alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .opr       (ir.opr),
      .opa       (ir.opa),
      .acc       (acc),
      .carry     (carry),
      .operand   (operand),
      .acc_nxt   (acc_nxt),
      .carry_nxt (carry_nxt),
      .reg_we    (reg_we),
      .reg_wdata (reg_wdata),
      .illegal   (alu_ill)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (accept)
               state_nxt = is_reg_op(opr) ? READ : EXEC;
         end
         READ:    state_nxt = EXEC;
         EXEC:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir          <= '0;
         operand     <= '0;
         acc         <= '0;
         carry       <= 1'b0;
         done        <= 1'b0;
         illegal     <= 1'b0;
         instr_count <= '0;
      end else begin
         if (accept)
            ir <= '{opr: opr, opa: opa};
         if (state == READ)
            operand <= regs[ridx];
         // done/illegal land in the first IDLE cycle
         done    <= exec;
         illegal <= exec && alu_ill;
         if (exec && !alu_ill) begin
            acc         <= acc_nxt;
            carry       <= carry_nxt;
            instr_count <= instr_count + CNT_W'(1);
         end
      end
   end

   // host write and XCH write never collide: IDLE vs EXEC
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= '0;
      end else begin
         if (host_ok)
            regs[host_addr] <= host_wdata;
         if (exec && reg_we && !alu_ill)
            regs[ridx] <= reg_wdata;
      end
   end

endmodule

// File: tb/tb_acc_exec_unit.sv
// tb_acc_exec_unit: directed + random checks of acc_exec_unit
// against an arithmetic reference model kept in the bench.
module tb_acc_exec_unit;

   localparam int W  = 4;
   localparam int NR = 16;
   localparam int CW = 4;
   localparam int M  = 16;
   localparam int CM = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          instr_valid = 1'b0;
   logic [3:0]    opr = '0;
   logic [3:0]    opa = '0;
   logic          instr_ready;
   logic          host_we = 1'b0;
   logic [3:0]    host_addr = '0;
   logic [W-1:0]  host_wdata = '0;
   logic [3:0]    rd_addr = '0;
   logic [W-1:0]  rd_data;
   logic [W-1:0]  acc;
   logic          carry;
   logic          done;
   logic          illegal;
   logic [CW-1:0] instr_count;

   int n_assert = 0;
   int n_fail   = 0;
   int ndone    = 0;
   int macc, mc, mcnt;
   int mreg [NR];

   always #5 clk = ~clk;

   always @(negedge clk) if (done === 1'b1) ndone++;

   acc_exec_unit #(
      .DATA_W (W),
      .NREG   (NR),
      .CNT_W  (CW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .opr         (opr),
      .opa         (opa),
      .instr_ready (instr_ready),
      .host_we     (host_we),
      .host_addr   (host_addr),
      .host_wdata  (host_wdata),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .acc         (acc),
      .carry       (carry),
      .done        (done),
      .illegal     (illegal),
      .instr_count (instr_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic model_reset();
      macc = 0;
      mc   = 0;
      mcnt = 0;
      for (int i = 0; i < NR; i++) mreg[i] = 0;
   endtask

   function automatic bit model_exec(input int o, input int a);
      int s, r, t;
      bit ill;
      r   = mreg[a];
      ill = 1'b0;
      case (o)
         0: ;
         8: begin
            s = macc + r + mc; macc = s % M; mc = s / M;
         end
         9: begin
            s = macc + (M - 1 - r) + (1 - mc);
            macc = s % M; mc = s / M;
         end
         10: macc = r;
         11: begin
            t = macc; macc = r; mreg[a] = t;
         end
         15: begin
            case (a)
               0: begin macc = 0; mc = 0; end
               1: mc = 0;
               2: begin s = macc + 1; macc = s % M; mc = s / M; end
               3: mc = 1 - mc;
               4: macc = M - 1 - macc;
               5: begin s = macc * 2 + mc; macc = s % M; mc = s / M; end
               6: begin s = mc * M + macc; mc = s % 2; macc = s / 2; end
               7: begin macc = mc; mc = 0; end
               8: begin s = macc + M - 1; macc = s % M; mc = s / M; end
               9: mc = 1;
               default: ill = 1'b1;
            endcase
         end
         default: ill = 1'b1;
      endcase
      if (!ill) mcnt = (mcnt + 1) % CM;
      return ill;
   endfunction

   task automatic host_wr(input int a, input int d);
      host_we    = 1'b1;
      host_addr  = 4'(a);
      host_wdata = W'(d);
      tick();
      host_we = 1'b0;
      mreg[a] = d;
   endtask

   task automatic issue(input int o, input int a, input string tag,
                        input int hw_a = -1, input int hw_d = 0);
      int lat, explat;
      bit ill;
      chk({tag, ":ready"}, instr_ready, 1);
      instr_valid = 1'b1;
      opr = 4'(o);
      opa = 4'(a);
      if (hw_a >= 0) begin
         host_we    = 1'b1;
         host_addr  = 4'(hw_a);
         host_wdata = W'(hw_d);
         mreg[hw_a] = hw_d;
      end
      tick();
      instr_valid = 1'b0;
      host_we     = 1'b0;
      opr = 4'($urandom);
      opa = 4'($urandom);
      lat = 1;
      while (done !== 1'b1 && lat < 8) begin
         tick();
         lat++;
      end
      explat = (o >= 8 && o <= 11) ? 3 : 2;
      ill = model_exec(o, a);
      chk({tag, ":latency"}, lat, explat);
      chk({tag, ":acc"}, acc, macc);
      chk({tag, ":carry"}, carry, mc);
      chk({tag, ":illegal"}, illegal, ill);
      chk({tag, ":count"}, instr_count, mcnt);
      rd_addr = 4'(a);
      #1;
      chk({tag, ":reg"}, rd_data, mreg[a]);
   endtask

   int d0, o, a, k;

   initial begin
      model_reset();
      #12;
      chk("rst:acc", acc, 0);
      chk("rst:carry", carry, 0);
      chk("rst:done", done, 0);
      chk("rst:illegal", illegal, 0);
      chk("rst:count", instr_count, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("rst:ready", instr_ready, 1);

      host_wr(2, 5);
      issue(10, 2, "ld");
      chk("ld:acc5", acc, 5);
      chk("ld:cnt1", instr_count, 1);

      issue(15, 0, "clb0");
      host_wr(4, 12);
      issue(10, 4, "ldc");
      issue(8, 2, "add");
      chk("add:acc1", acc, 1);
      chk("add:c1", carry, 1);
      issue(9, 2, "sub");
      chk("sub:accb", acc, 11);
      chk("sub:c0", carry, 0);

      issue(15, 0, "clb1");
      host_wr(5, 9);
      issue(10, 5, "ld9");
      issue(15, 5, "ral");
      chk("ral:acc2", acc, 2);
      chk("ral:c1", carry, 1);
      issue(15, 6, "rar");
      chk("rar:acc9", acc, 9);
      chk("rar:c0", carry, 0);
      issue(15, 0, "clb2");
      issue(15, 8, "dac");
      chk("dac:accf", acc, 15);
      chk("dac:c0", carry, 0);
      issue(15, 2, "iac");
      chk("iac:acc0", acc, 0);
      chk("iac:c1", carry, 1);

      host_wr(6, 7);
      issue(10, 6, "ld7");
      host_wr(3, 10);
      d0 = ndone;
      instr_valid = 1'b1;
      opr = 4'hB;
      opa = 4'h3;
      tick();
      host_we    = 1'b1;
      host_addr  = 4'h9;
      host_wdata = 4'hF;
      opr = 4'h8;
      opa = 4'h5;
      tick();
      host_we = 1'b0;
      opr = 4'hA;
      opa = 4'h6;
      tick();
      chk("xch:done", done, 1);
      instr_valid = 1'b0;
      tick();
      tick();
      chk("xch:ndone", ndone - d0, 1);
      void'(model_exec(11, 3));
      chk("xch:accA", acc, 10);
      chk("xch:count", instr_count, mcnt);
      rd_addr = 4'h3;
      #1;
      chk("xch:r3", rd_data, 7);
      rd_addr = 4'h9;
      #1;
      chk("busy_hw:r9", rd_data, 0);

      host_wr(2, 5);
      instr_valid = 1'b1;
      opr = 4'h8;
      opa = 4'h2;
      tick();
      instr_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("rstx:acc", acc, 0);
      chk("rstx:carry", carry, 0);
      chk("rstx:count", instr_count, 0);
      chk("rstx:done", done, 0);
      chk("rstx:ready", instr_ready, 1);
      for (int i = 0; i < NR; i++) begin
         rd_addr = 4'(i);
         #1;
         chk("rstx:reg", rd_data, 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      d0 = ndone;
      tick();
      tick();
      chk("rstx:nodone", ndone - d0, 0);
      chk("rstx:acc2", acc, 0);

      issue(15, 9, "stc");
      issue(15, 4, "cma");
      issue(15, 10, "ill_a");
      chk("ill_a:flag", illegal, 1);
      chk("ill_a:done", done, 1);
      chk("ill_a:acc", acc, 15);
      chk("ill_a:cnt", instr_count, 2);
      issue(3, 1, "ill_o");
      issue(15, 7, "tcc");
      issue(15, 3, "cmc");
      issue(15, 1, "clc");

      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 16; i++) begin
         issue(0, int'($urandom_range(0, 15)), "nop");
         if (i == 14) chk("nop:cnt15", instr_count, 15);
      end
      chk("nop:wrap0", instr_count, 0);

      for (int i = 0; i < NR; i++)
         host_wr(i, int'($urandom_range(0, M - 1)));
      for (int i = 0; i < 120; i++) begin
         k = int'($urandom_range(0, 9));
         a = int'($urandom_range(0, 15));
         if (k < 4)      o = 8 + k;
         else if (k < 7) begin
            o = 15;
            a = int'($urandom_range(0, 9));
         end
         else if (k == 7) o = 0;
         else if (k == 8) o = ($urandom_range(0, 1) == 1) ? 15 :
                              int'($urandom_range(1, 7));
         else begin
            host_wr(a, int'($urandom_range(0, M - 1)));
            o = 8 + int'($urandom_range(0, 3));
         end
         if ($urandom_range(0, 3) == 0)
            issue(o, a, "rnd_hw", a, int'($urandom_range(0, M - 1)));
         else
            issue(o, a, "rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
